// File: rtl/cpu_pkg.sv
`default_nettype none
// =============================================================================
// Module   : cpu_pkg
// Purpose  : Shared encodings for cpu_controller: FSM states, opcode/op fields,
//            instruction classes, writeback and ALU codes.
// Revision : 1.0  initial release
// =============================================================================
package cpu_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVI  = 2'b10;
    localparam logic [1:0] OP_MOVR  = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b00;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_CMP  = 2'b01;

    localparam logic [1:0] WB_C     = 2'b00;
    localparam logic [1:0] WB_PC    = 2'b01;
    localparam logic [1:0] WB_IMM   = 2'b10;
    localparam logic [1:0] WB_MEM   = 2'b11;

`ifdef CPU_BRANCH_EN
    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] COND_B   = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_NE  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_LE  = 3'b100;
`endif

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_WRIMM  = 4'd3,
        S_GET_A  = 4'd4,
        S_GET_B  = 4'd5,
        S_EXEC   = 4'd6,
        S_WRC    = 4'd7,
        S_ADDR   = 4'd8,
        S_LATCH  = 4'd9,
        S_MRD    = 4'd10,
        S_WRM    = 4'd11,
        S_PASS   = 4'd12,
        S_MWR    = 4'd13,
        S_HALT   = 4'd14
`ifdef CPU_BRANCH_EN
        ,
        S_BRANCH = 4'd15
`endif
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP  = 4'd0,
        CL_MOVI = 4'd1,
        CL_MOVR = 4'd2,
        CL_ALU  = 4'd3,
        CL_CMP  = 4'd4,
        CL_LDR  = 4'd5,
        CL_STR  = 4'd6,
        CL_HALT = 4'd7
`ifdef CPU_BRANCH_EN
        ,
        CL_BR   = 4'd8
`endif
    } iclass_t;

`ifdef CPU_BRANCH_EN
    // Flags reflect the status register, i.e. the most recent CMP.
    function automatic logic br_taken(input logic [2:0] cond, input logic z,
                                      input logic n, input logic v);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_B:  taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_LT: taken = n ^ v;
            COND_LE: taken = z | (n ^ v);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// =============================================================================
// Module   : cpu_decoder
// Purpose  : Combinational instruction decode: register fields, immediates and
//            instruction class. Branch class exists only with CPU_BRANCH_EN.
// Revision : 1.0  initial release
// =============================================================================
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [1:0]  op_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [1:0]  sh_o,
    output logic [2:0]  rm_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o,
    output iclass_t     cls_o
);

    logic [2:0] w_opc;

    assign w_opc    = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

    // Unrecognised encodings fall through as CL_NOP.
    always_comb begin
        cls_o = CL_NOP;
        case (w_opc)
            OPC_MOV: begin
                if (op_o == OP_MOVI)
                    cls_o = CL_MOVI;
                else if (op_o == OP_MOVR)
                    cls_o = CL_MOVR;
            end
            OPC_ALU:  cls_o = (op_o == ALU_CMP) ? CL_CMP : CL_ALU;
            OPC_LDR:  if (op_o == OP_MEM) cls_o = CL_LDR;
            OPC_STR:  if (op_o == OP_MEM) cls_o = CL_STR;
            OPC_HALT: cls_o = CL_HALT;
`ifdef CPU_BRANCH_EN
            OPC_BR:   cls_o = CL_BR;
`endif
            default:  cls_o = CL_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// =============================================================================
// Module   : cpu_controller
// Purpose  : Multi-cycle sequencer for the 16-bit RISC datapath; owns PC, IR
//            and DAR. Define CPU_BRANCH_EN to add conditional branches.
// Revision : 1.0  initial release
// =============================================================================
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [PC_W-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [15:0]     mem_rdata_i,
    input  logic [15:0]     dp_out_i,
    input  logic            z_i,
    input  logic            n_i,
    input  logic            v_i,
    output logic [2:0]      r_addr_o,
    output logic [2:0]      w_addr_o,
    output logic            w_en_o,
    output logic            en_a_o,
    output logic            en_b_o,
    output logic            en_c_o,
    output logic            en_status_o,
    output logic            sel_a_o,
    output logic            sel_b_o,
    output logic [1:0]      wb_sel_o,
    output logic [1:0]      shift_op_o,
    output logic [1:0]      alu_op_o,
    output logic [15:0]     sximm8_o,
    output logic [15:0]     sximm5_o,
    output logic [PC_W-1:0] pc_o,
    output logic            halted_o
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] dar_q, dar_d;
    logic [15:0]     ir_q, ir_d;

    logic [1:0]      w_op;
    logic [2:0]      w_rn;
    logic [2:0]      w_rd;
    logic [1:0]      w_sh;
    logic [2:0]      w_rm;
    logic [15:0]     w_sximm8;
    logic [15:0]     w_sximm5;
    iclass_t         w_cls;

    cpu_decoder u_decoder (
        .ir_i     (ir_q),
        .op_o     (w_op),
        .rn_o     (w_rn),
        .rd_o     (w_rd),
        .sh_o     (w_sh),
        .rm_o     (w_rm),
        .sximm8_o (w_sximm8),
        .sximm5_o (w_sximm5),
        .cls_o    (w_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            dar_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dar_q   <= dar_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dar_d   = dar_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack_i) begin
                    ir_d    = mem_rdata_i;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (w_cls)
                    CL_MOVI:                         state_d = S_WRIMM;
                    CL_MOVR:                         state_d = S_GET_B;
                    CL_ALU, CL_CMP, CL_LDR, CL_STR:  state_d = S_GET_A;
                    CL_HALT:                         state_d = S_HALT;
`ifdef CPU_BRANCH_EN
                    CL_BR:                           state_d = S_BRANCH;
`endif
                    default:                         state_d = S_FETCH;
                endcase
            end
            S_WRIMM:  state_d = S_FETCH;
            S_GET_A:  state_d = (w_cls == CL_LDR || w_cls == CL_STR) ? S_ADDR : S_GET_B;
            S_GET_B:  state_d = (w_cls == CL_STR) ? S_PASS : S_EXEC;
            S_EXEC:   state_d = (w_cls == CL_CMP) ? S_FETCH : S_WRC;
            S_WRC:    state_d = S_FETCH;
            S_ADDR:   state_d = S_LATCH;
            S_LATCH: begin
                // Only the low PC_W bits of the computed address are meaningful.
                dar_d   = dp_out_i[PC_W-1:0];
                state_d = (w_cls == CL_LDR) ? S_MRD : S_GET_B;
            end
            S_MRD:    if (mem_ack_i) state_d = S_WRM;
            S_WRM:    state_d = S_FETCH;
            S_PASS:   state_d = S_MWR;
            S_MWR:    if (mem_ack_i) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
`ifdef CPU_BRANCH_EN
            S_BRANCH: begin
                if (br_taken(w_rn, z_i, n_i, v_i))
                    pc_d = pc_q + w_sximm8[PC_W-1:0];
                state_d = S_FETCH;
            end
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        r_addr_o    = '0;
        w_addr_o    = '0;
        w_en_o      = 1'b0;
        en_a_o      = 1'b0;
        en_b_o      = 1'b0;
        en_c_o      = 1'b0;
        en_status_o = 1'b0;
        sel_a_o     = 1'b0;
        sel_b_o     = 1'b0;
        wb_sel_o    = WB_C;
        shift_op_o  = 2'b00;
        alu_op_o    = ALU_ADD;
        halted_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_q;
            end
            S_WRIMM: begin
                w_addr_o = w_rn;
                wb_sel_o = WB_IMM;
                w_en_o   = 1'b1;
            end
            S_GET_A: begin
                r_addr_o = w_rn;
                en_a_o   = 1'b1;
            end
            S_GET_B: begin
                r_addr_o = (w_cls == CL_STR) ? w_rd : w_rm;
                en_b_o   = 1'b1;
            end
            S_EXEC: begin
                // MOV reg passes B through the adder with A zeroed.
                sel_a_o     = (w_cls != CL_MOVR);
                alu_op_o    = (w_cls == CL_MOVR) ? ALU_ADD : w_op;
                shift_op_o  = w_sh;
                en_status_o = (w_cls == CL_CMP);
                en_c_o      = (w_cls != CL_CMP);
            end
            S_WRC: begin
                w_addr_o = w_rd;
                wb_sel_o = WB_C;
                w_en_o   = 1'b1;
            end
            S_ADDR: begin
                sel_a_o = 1'b1;
                sel_b_o = 1'b1;
                en_c_o  = 1'b1;
            end
            S_MRD: begin
                mem_req_o  = 1'b1;
                mem_addr_o = dar_q;
            end
            S_WRM: begin
                w_addr_o = w_rd;
                wb_sel_o = WB_MEM;
                w_en_o   = 1'b1;
            end
            S_PASS:  en_c_o = 1'b1;
            S_MWR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = dar_q;
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

    assign sximm8_o = w_sximm8;
    assign sximm5_o = w_sximm5;
    assign pc_o     = pc_q;

    logic w_unused;
`ifdef CPU_BRANCH_EN
    assign w_unused = ^dp_out_i;
`else
    assign w_unused = ^{dp_out_i, z_i, n_i, v_i};
`endif

endmodule
`default_nettype wire
